// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose:
//   A valid/ready pipeline stage that holds up to two entries: a main register
//   that drives out_data, and a skid register that catches one entry when the
//   downstream stalls. Because of the skid register, in_ready depends only on
//   the stage's own state, not on out_ready. Every output comes from a flop or
//   is decoded from the state register, so no input reaches an output through
//   combinational logic. A saturating counter records how many cycles the stage
//   offered valid data that the downstream refused.
//
// Parameters:
//   WIDTH      payload width in bits (1..256)
//   NOP_VALUE  bubble payload held in empty registers
//   CNT_W      width of the stall counter
//
// Ports:
//   CLK        clock; all state updates on the rising edge
//   RST        synchronous active-high reset
//   flush      discard every held entry at the next edge
//   in_valid   upstream offers in_data
//   in_data    upstream payload
//   in_ready   stage can accept this cycle (state != FULL)
//   out_valid  out_data holds a valid entry (state != EMPTY)
//   out_data   downstream payload (main register)
//   out_ready  downstream consumes this cycle; low means stall
//   occupancy  number of held entries, 0..2
//   stall_cnt  saturating count of stall cycles
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   NOP_VALUE = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic               in_xfer;
  logic               out_xfer;

  // State and datapath registers. Reset takes priority over flush and over
  // every transfer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= EMPTY;
      main_q      <= NOP_VALUE;
      skid_q      <= NOP_VALUE;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state and datapath logic. The handshake signals use the state-decoded
  // in_ready/out_valid, so in FULL the in_valid input is ignored.
  // Empty registers are always reloaded with NOP_VALUE, which keeps out_data
  // at the bubble value whenever nothing valid is held.
  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    stall_cnt_d = stall_cnt_q;

    in_xfer  = in_valid & in_ready;
    out_xfer = out_valid & out_ready;

    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = in_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_xfer) begin
            main_d  = NOP_VALUE;
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
            state_d = BUSY;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end

    // A stall is a cycle where valid data is refused. A flush cycle is not
    // counted, and the counter sticks at its maximum instead of wrapping.
    if (out_valid && !out_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Output decode: handshake levels and occupancy come from state only.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (state_q)
      EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
      BUSY: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
    endcase
  end

  assign out_data  = main_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Purpose:
//   Self-checking bench for pipe_stage_reg. A queue holds the entries the stage
//   should currently contain; accepted inputs are pushed, delivered outputs
//   popped, and every cycle the DUT outputs are compared with the queue head,
//   the queue depth and a model of the stall counter.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int               WIDTH     = 16;
  localparam logic [WIDTH-1:0] NOP_VALUE = 16'hDEAD;
  localparam int               CNT_W     = 4;
  localparam int               CNT_MAX   = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  logic [WIDTH-1:0] sbQueue[$];
  int               modelStall = 0;
  int               passCount  = 0;
  int               checkCount = 0;

  pipe_stage_reg #(
    .WIDTH    (WIDTH),
    .NOP_VALUE(NOP_VALUE),
    .CNT_W    (CNT_W)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  // Free-running clock, 10 time units per period.
  always #5 CLK = ~CLK;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Compare all DUT outputs against the scoreboard queue and stall model.
  task automatic checkState(input string tag);
    logic [WIDTH-1:0] expData;
    expData = (sbQueue.size() > 0) ? sbQueue[0] : NOP_VALUE;
    checkOutput({tag, ".out_data"},  32'(out_data),  32'(expData));
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(sbQueue.size() > 0));
    checkOutput({tag, ".in_ready"},  32'(in_ready),  32'(sbQueue.size() < 2));
    checkOutput({tag, ".occupancy"}, 32'(occupancy), 32'(sbQueue.size()));
    checkOutput({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(modelStall));
  endtask

  // Drive one cycle of inputs, advance the model across the clock edge, then
  // compare outputs shortly after the edge.
  task automatic applyStimulus(input string tag, input logic iv,
                               input logic [WIDTH-1:0] id, input logic ordy,
                               input logic fl, input logic rs);
    logic modelInReady;
    logic modelOutValid;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    RST       = rs;
    modelInReady  = (sbQueue.size() < 2);
    modelOutValid = (sbQueue.size() > 0);
    @(posedge CLK);
    if (rs) begin
      sbQueue.delete();
      modelStall = 0;
    end else if (fl) begin
      sbQueue.delete();
    end else begin
      if (modelOutValid && !ordy && modelStall < CNT_MAX) modelStall++;
      if (modelOutValid && ordy) void'(sbQueue.pop_front());
      if (iv && modelInReady) sbQueue.push_back(id);
    end
    #1;
    checkState(tag);
  endtask

  initial begin
    RST       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state.
    applyStimulus("reset0", 1'b1, 16'h1111, 1'b1, 1'b1, 1'b1);
    applyStimulus("reset1", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    checkOutput("reset.in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset.out_data", 32'(out_data), 32'(NOP_VALUE));

    // Streaming at full throughput: occupancy stays at one.
    for (int i = 1; i <= 10; i++) begin
      applyStimulus("stream", 1'b1, WIDTH'(i), 1'b1, 1'b0, 1'b0);
      checkOutput("stream.occ", 32'(occupancy), 32'd1);
    end
    applyStimulus("stream.drain", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

    // Backpressure: A held, B caught in skid, C refused then re-offered.
    applyStimulus("bp.loadA", 1'b1, 16'h000A, 1'b1, 1'b0, 1'b0);
    applyStimulus("bp.offerB", 1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
    checkOutput("bp.full.in_ready", 32'(in_ready), 32'd0);
    applyStimulus("bp.offerC", 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0);
    checkOutput("bp.Cheld.out_data", 32'(out_data), 32'h000A);
    applyStimulus("bp.popA", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    checkOutput("bp.B.out_data", 32'(out_data), 32'h000B);
    applyStimulus("bp.reofferC", 1'b1, 16'h000C, 1'b1, 1'b0, 1'b0);
    checkOutput("bp.C.out_data", 32'(out_data), 32'h000C);
    applyStimulus("bp.popC", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Flush colliding with input and output transfer while FULL.
    applyStimulus("fl.fill1", 1'b1, 16'h0101, 1'b0, 1'b0, 1'b0);
    applyStimulus("fl.fill2", 1'b1, 16'h0202, 1'b0, 1'b0, 1'b0);
    applyStimulus("fl.collide", 1'b1, 16'h0303, 1'b1, 1'b1, 1'b0);
    checkOutput("fl.occ", 32'(occupancy), 32'd0);
    checkOutput("fl.out_data", 32'(out_data), 32'(NOP_VALUE));
    applyStimulus("fl.idle", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Saturation of the stall counter.
    applyStimulus("sat.reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    applyStimulus("sat.load", 1'b1, 16'h0055, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus("sat.stall", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("sat.stall_cnt", 32'(stall_cnt), 32'(CNT_MAX));

    // Reset asserted mid-operation while FULL with stall count 5.
    applyStimulus("rm.reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    applyStimulus("rm.load1", 1'b1, 16'h0007, 1'b0, 1'b0, 1'b0);
    applyStimulus("rm.load2", 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("rm.stall", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("rm.pre.stall_cnt", 32'(stall_cnt), 32'd5);
    checkOutput("rm.pre.occ", 32'(occupancy), 32'd2);
    applyStimulus("rm.hit", 1'b1, 16'h0009, 1'b1, 1'b1, 1'b1);
    checkOutput("rm.post.stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("rm.post.out_data", 32'(out_data), 32'(NOP_VALUE));

    // Random traffic with occasional flush.
    for (int i = 0; i < 300; i++) begin
      applyStimulus("rand",
                    1'($urandom_range(0, 1)),
                    WIDTH'($urandom),
                    1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 19) == 0),
                    1'b0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
